// File: rtl/id_stage_sb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : id_stage_sb_pkg                                           |
// | Purpose  : LC-3b types, control word and control ROM for the         |
// |            scoreboarded decode stage                                 |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package id_stage_sb_pkg;

    localparam int LC3B_NREGS = 8;
    localparam int LC3B_CNTW  = 2;

    typedef logic [LC3B_CNTW-1:0]          lc3b_sb_count;
    typedef logic [$clog2(LC3B_NREGS)-1:0] lc3b_reg;

    localparam lc3b_reg LC3B_R7 = 3'd7;

    typedef enum logic [3:0] {
        OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LDB = 4'b0010, OP_STB  = 4'b0011,
        OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR  = 4'b0111,
        OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI  = 4'b1011,
        OP_JMP = 4'b1100, OP_SHF = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
    } lc3b_opcode;

    // Immediate chosen for the SR2 operand slot
    typedef enum logic [1:0] {
        IMM_ZEXT4 = 2'd0, IMM_SEXT5 = 2'd1, IMM_SEXT6 = 2'd2, IMM_ADJ6 = 2'd3
    } lc3b_sr2mux_sel;

    // Dest register as a source: none, as-is, or placed in the upper byte
    typedef enum logic [1:0] {
        DEST_NONE = 2'd0, DEST_PLAIN = 2'd1, DEST_HIGH = 2'd2
    } lc3b_destmux_sel;

    typedef struct packed {
        lc3b_opcode      opcode;
        logic            load_regfile;
        logic            load_cc;
        logic            sr2mux2;      // 0 = register SR2, 1 = immediate
        lc3b_sr2mux_sel  sr2mux;
        lc3b_destmux_sel destmux;
        logic            writemux;     // 1 = write R7 (link register)
        logic            mem_read;
        logic            mem_write;
    } lc3b_control_word;

    // Opcode to control word; imm_sel is IR[5] for the ADD/AND register/immediate form
    function automatic lc3b_control_word control_rom(input lc3b_opcode op, input logic imm_sel);
        lc3b_control_word c;
        c         = '0;
        c.opcode  = op;
        c.sr2mux2 = 1'b1;
        c.sr2mux  = IMM_SEXT5;
        c.destmux = DEST_NONE;
        case (op)
            OP_ADD, OP_AND: begin
                c.load_regfile = 1'b1; c.load_cc = 1'b1; c.sr2mux2 = imm_sel;
            end
            OP_NOT:  begin c.load_regfile = 1'b1; c.load_cc = 1'b1; end
            OP_SHF:  begin c.load_regfile = 1'b1; c.load_cc = 1'b1; c.sr2mux = IMM_ZEXT4; end
            OP_LDR, OP_LDI: begin
                c.load_regfile = 1'b1; c.load_cc = 1'b1; c.sr2mux = IMM_ADJ6; c.mem_read = 1'b1;
            end
            OP_LDB:  begin
                c.load_regfile = 1'b1; c.load_cc = 1'b1; c.sr2mux = IMM_SEXT6; c.mem_read = 1'b1;
            end
            OP_STR, OP_STI: begin
                c.sr2mux = IMM_ADJ6; c.destmux = DEST_PLAIN; c.mem_write = 1'b1;
            end
            OP_STB:  begin c.sr2mux = IMM_SEXT6; c.destmux = DEST_HIGH; c.mem_write = 1'b1; end
            OP_JSR, OP_TRAP: begin c.load_regfile = 1'b1; c.writemux = 1'b1; end
            OP_LEA:  c.load_regfile = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : id_scoreboard                                             |
// | Purpose  : Per-register pending-write counters, RAW hazard check,    |
// |            issue/writeback/rollback arithmetic and sticky error      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module id_scoreboard
    import id_stage_sb_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int CNTW  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] i_src1,
    input  logic [$clog2(NREGS)-1:0] i_src2,
    input  logic [$clog2(NREGS)-1:0] i_src3,
    input  logic [2:0]               i_use,
    input  logic                     i_wr_en,
    input  logic [$clog2(NREGS)-1:0] i_wr_idx,
    input  logic                     i_issue,
    input  logic                     i_wb_valid,
    input  logic [$clog2(NREGS)-1:0] i_wb_reg,
    input  logic                     i_rb_valid,
    input  logic [$clog2(NREGS)-1:0] i_rb_idx,
    output logic                     o_hazard,
    output logic                     o_sb_err
);

    localparam int c_rw = $clog2(NREGS);

    logic [CNTW-1:0] r_count [NREGS];
    logic [CNTW-1:0] w_next  [NREGS];
    logic [CNTW:0]   w_sum   [NREGS];
    logic [NREGS-1:0] w_err;
    logic [c_rw-1:0] w_src   [3];
    logic            w_hazard;
    logic            r_err;

    assign w_src[0] = i_src1;
    assign w_src[1] = i_src2;
    assign w_src[2] = i_src3;

    // RAW check per used source (a lone pending write retiring this cycle is bypassed),
    // plus refusal to issue a writer whose destination counter is saturated
    always_comb begin
        w_hazard = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (i_use[s] && (r_count[w_src[s]] != '0) &&
                !((r_count[w_src[s]] == CNTW'(1)) && i_wb_valid && (i_wb_reg == w_src[s])))
                w_hazard = 1'b1;
        end
        if (i_wr_en && (r_count[i_wr_idx] == '1))
            w_hazard = 1'b1;
    end

    // Net counter change; a negative result floors at zero and flags a stray writeback
    always_comb begin
        w_sum  = '{default: '0};
        w_next = '{default: '0};
        w_err  = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_sum[r] = {1'b0, r_count[r]}
                     + (CNTW+1)'(i_issue && i_wr_en && (i_wr_idx == c_rw'(r)))
                     - (CNTW+1)'(i_wb_valid && (i_wb_reg == c_rw'(r)))
                     - (CNTW+1)'(i_rb_valid && (i_rb_idx == c_rw'(r)));
            w_next[r] = w_sum[r][CNTW] ? '0 : w_sum[r][CNTW-1:0];
            w_err[r]  = w_sum[r][CNTW] && i_wb_valid && (i_wb_reg == c_rw'(r));
        end
    end

    // Counter state and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) r_count[r] <= '0;
            r_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) r_count[r] <= w_next[r];
            r_err <= r_err | (|w_err);
        end
    end

    assign o_hazard = w_hazard;
    assign o_sb_err = r_err;

endmodule
`default_nettype wire

// File: rtl/id_stage_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : id_stage_sb                                               |
// | Purpose  : LC-3b decode stage with bypassed register file, RAW       |
// |            scoreboard and ID/EX pipeline register                    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module id_stage_sb
    import id_stage_sb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int CNTW  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_valid,
    input  logic [WIDTH-1:0]         instruction,
    output logic                     id_ready,
    input  logic                     flush,
    input  logic                     ex_ready,
    input  logic                     wb_valid,
    input  logic [$clog2(NREGS)-1:0] wb_reg,
    input  logic [WIDTH-1:0]         wb_data,
    output logic                     ex_valid,
    output lc3b_control_word         ex_ctrl,
    output logic [WIDTH-1:0]         ex_sr1,
    output logic [WIDTH-1:0]         ex_sr2,
    output logic [WIDTH-1:0]         ex_dest_val,
    output logic [$clog2(NREGS)-1:0] ex_dest_reg,
    output logic [7:0]               ex_offset8,
    output logic [8:0]               ex_offset9,
    output logic [10:0]              ex_offset11,
    output logic                     hazard_stall,
    output logic                     sb_err
);

    localparam int              c_rw = $clog2(NREGS);
    localparam logic [c_rw-1:0] c_r7 = c_rw'(LC3B_R7);

    lc3b_opcode       w_opcode;
    lc3b_control_word w_ctrl;
    logic [c_rw-1:0]  w_sr1_idx, w_sr2_idx, w_dst_idx, w_wr_idx;
    logic [WIDTH-1:0] w_sr1_val, w_sr2_val, w_dst_val, w_imm, w_sr2_op, w_dest_op;
    logic             w_hazard, w_issue, w_rollback, w_sb_err;
    logic [WIDTH-1:0] r_regs [NREGS];

    logic             r_ex_valid;
    lc3b_control_word r_ex_ctrl;
    logic [WIDTH-1:0] r_ex_sr1, r_ex_sr2, r_ex_dest_val;
    logic [c_rw-1:0]  r_ex_dest_reg;
    logic [7:0]       r_ex_offset8;
    logic [8:0]       r_ex_offset9;
    logic [10:0]      r_ex_offset11;

    assign w_opcode  = lc3b_opcode'(instruction[15:12]);
    assign w_ctrl    = control_rom(w_opcode, instruction[5]);
    assign w_dst_idx = c_rw'(instruction[11:9]);
    assign w_sr1_idx = c_rw'(instruction[8:6]);
    assign w_sr2_idx = c_rw'(instruction[2:0]);
    assign w_wr_idx  = w_ctrl.writemux ? c_r7 : w_dst_idx;

    // Register file write on writeback; R0 is ordinary storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (wb_valid) begin
            r_regs[wb_reg] <= wb_data;
        end
    end

    // Same-cycle writeback data overrides the stored value on every read port
    assign w_sr1_val = (wb_valid && (wb_reg == w_sr1_idx)) ? wb_data : r_regs[w_sr1_idx];
    assign w_sr2_val = (wb_valid && (wb_reg == w_sr2_idx)) ? wb_data : r_regs[w_sr2_idx];
    assign w_dst_val = (wb_valid && (wb_reg == w_dst_idx)) ? wb_data : r_regs[w_dst_idx];

    // Immediate generation selected by the control word
    always_comb begin
        w_imm = '0;
        case (w_ctrl.sr2mux)
            IMM_ZEXT4: w_imm = {{(WIDTH-4){1'b0}}, instruction[3:0]};
            IMM_SEXT5: w_imm = {{(WIDTH-5){instruction[4]}}, instruction[4:0]};
            IMM_SEXT6: w_imm = {{(WIDTH-6){instruction[5]}}, instruction[5:0]};
            IMM_ADJ6:  w_imm = {{(WIDTH-7){instruction[5]}}, instruction[5:0], 1'b0};
            default:   w_imm = '0;
        endcase
    end

    assign w_sr2_op  = w_ctrl.sr2mux2 ? w_imm : w_sr2_val;
    assign w_dest_op = (w_ctrl.destmux == DEST_HIGH) ? {w_dst_val[WIDTH-9:0], 8'h00} : w_dst_val;

    // A flushed writer never reaches writeback, so its pending count is returned
    assign w_rollback = flush && r_ex_valid && r_ex_ctrl.load_regfile;

    id_scoreboard #(
        .NREGS (NREGS),
        .CNTW  (CNTW)
    ) u_sb (
        .clk        (clk),
        .rst        (reset),
        .i_src1     (w_sr1_idx),
        .i_src2     (w_sr2_idx),
        .i_src3     (w_dst_idx),
        .i_use      ({(w_ctrl.destmux != DEST_NONE), !w_ctrl.sr2mux2, 1'b1}),
        .i_wr_en    (w_ctrl.load_regfile),
        .i_wr_idx   (w_wr_idx),
        .i_issue    (w_issue),
        .i_wb_valid (wb_valid),
        .i_wb_reg   (wb_reg),
        .i_rb_valid (w_rollback),
        .i_rb_idx   (r_ex_dest_reg),
        .o_hazard   (w_hazard),
        .o_sb_err   (w_sb_err)
    );

    assign id_ready     = !w_hazard && !flush && (!r_ex_valid || ex_ready);
    assign w_issue      = if_valid && id_ready;
    assign hazard_stall = if_valid && w_hazard;
    assign sb_err       = w_sb_err;

    // ID/EX slot: flush squashes, issue loads, consumption without refill empties
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid    <= 1'b0;
            r_ex_ctrl     <= '0;
            r_ex_sr1      <= '0;
            r_ex_sr2      <= '0;
            r_ex_dest_val <= '0;
            r_ex_dest_reg <= '0;
            r_ex_offset8  <= '0;
            r_ex_offset9  <= '0;
            r_ex_offset11 <= '0;
        end else if (flush) begin
            r_ex_valid    <= 1'b0;
        end else if (w_issue) begin
            r_ex_valid    <= 1'b1;
            r_ex_ctrl     <= w_ctrl;
            r_ex_sr1      <= w_sr1_val;
            r_ex_sr2      <= w_sr2_op;
            r_ex_dest_val <= w_dest_op;
            r_ex_dest_reg <= w_wr_idx;
            r_ex_offset8  <= instruction[7:0];
            r_ex_offset9  <= instruction[8:0];
            r_ex_offset11 <= instruction[10:0];
        end else if (ex_ready) begin
            r_ex_valid    <= 1'b0;
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_ctrl     = r_ex_ctrl;
    assign ex_sr1      = r_ex_sr1;
    assign ex_sr2      = r_ex_sr2;
    assign ex_dest_val = r_ex_dest_val;
    assign ex_dest_reg = r_ex_dest_reg;
    assign ex_offset8  = r_ex_offset8;
    assign ex_offset9  = r_ex_offset9;
    assign ex_offset11 = r_ex_offset11;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_id_stage_sb                                            |
// | Purpose  : Directed self-checking bench for id_stage_sb              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_id_stage_sb;
    import id_stage_sb_pkg::*;

    logic             clk = 1'b0;
    logic             reset, if_valid, flush, ex_ready, wb_valid;
    logic [15:0]      instruction, wb_data;
    logic [2:0]       wb_reg;
    logic             id_ready, ex_valid, hazard_stall, sb_err;
    lc3b_control_word ex_ctrl;
    logic [15:0]      ex_sr1, ex_sr2, ex_dest_val;
    logic [2:0]       ex_dest_reg;
    logic [7:0]       ex_offset8;
    logic [8:0]       ex_offset9;
    logic [10:0]      ex_offset11;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_stage_sb #(.WIDTH(16), .NREGS(8), .CNTW(2)) u_dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .instruction(instruction),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_sr1(ex_sr1), .ex_sr2(ex_sr2),
        .ex_dest_val(ex_dest_val), .ex_dest_reg(ex_dest_reg),
        .ex_offset8(ex_offset8), .ex_offset9(ex_offset9), .ex_offset11(ex_offset11),
        .hazard_stall(hazard_stall), .sb_err(sb_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [2:0] r, input logic [15:0] d);
        wb_valid = 1'b1; wb_reg = r; wb_data = d;
    endtask

    initial begin
        reset = 1'b1; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0; instruction = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_eq("rst_ex_valid", 32'(ex_valid), 0);
        check_eq("rst_sb_err",   32'(sb_err), 0);
        check_eq("rst_ex_sr1",   32'(ex_sr1), 0);
        check_eq("rst_id_ready", 32'(id_ready), 1);
        check_eq("rst_cnt1",     32'(u_dut.u_sb.r_count[1]), 0);

        // RAW hazard on R1, released by writeback bypass
        ex_ready = 1'b1; if_valid = 1'b1; instruction = 16'h1283;   // ADD R1,R2,R3
        #1 check_eq("add1_ready", 32'(id_ready), 1);
        tick();
        check_eq("add1_valid", 32'(ex_valid), 1);
        check_eq("add1_dest",  32'(ex_dest_reg), 1);
        check_eq("add1_op",    32'(ex_ctrl.opcode), 32'h1);
        check_eq("add1_cnt1",  32'(u_dut.u_sb.r_count[1]), 1);
        instruction = 16'h1865;                                     // ADD R4,R1,#5
        #1 check_eq("raw_stall", 32'(hazard_stall), 1);
        check_eq("raw_ready", 32'(id_ready), 0);
        tick();
        check_eq("raw_drain", 32'(ex_valid), 0);
        check_eq("raw_stall2", 32'(hazard_stall), 1);
        wb(3'd1, 16'h00AA);
        #1 check_eq("byp_stall", 32'(hazard_stall), 0);
        check_eq("byp_ready", 32'(id_ready), 1);
        tick();
        wb_valid = 1'b0;
        check_eq("byp_valid", 32'(ex_valid), 1);
        check_eq("byp_sr1",   32'(ex_sr1), 32'h00AA);
        check_eq("byp_sr2",   32'(ex_sr2), 32'h0005);
        check_eq("byp_dest",  32'(ex_dest_reg), 4);
        check_eq("byp_off9",  32'(ex_offset9), 32'h065);
        check_eq("byp_cnt1",  32'(u_dut.u_sb.r_count[1]), 0);
        check_eq("byp_cnt4",  32'(u_dut.u_sb.r_count[4]), 1);

        // Back-pressure: slot holds, next instruction refused
        ex_ready = 1'b0; instruction = 16'h1621;                    // ADD R3,R0,#1
        #1 check_eq("bp_ready", 32'(id_ready), 0);
        check_eq("bp_stall", 32'(hazard_stall), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_valid", 32'(ex_valid), 1);
            check_eq("bp_sr1",   32'(ex_sr1), 32'h00AA);
            check_eq("bp_sr2",   32'(ex_sr2), 32'h0005);
            check_eq("bp_dest",  32'(ex_dest_reg), 4);
            check_eq("bp_ready_hold", 32'(id_ready), 0);
        end
        ex_ready = 1'b1;
        #1 check_eq("bp_release", 32'(id_ready), 1);
        tick();
        check_eq("bp_next_dest", 32'(ex_dest_reg), 3);
        check_eq("bp_next_sr2",  32'(ex_sr2), 1);
        if_valid = 1'b0;
        wb(3'd4, 16'h0044);
        tick();
        wb(3'd3, 16'h0033);
        tick();
        wb_valid = 1'b0;
        check_eq("ret_cnt3", 32'(u_dut.u_sb.r_count[3]), 0);
        check_eq("ret_cnt4", 32'(u_dut.u_sb.r_count[4]), 0);
        check_eq("ret_err",  32'(sb_err), 0);

        // Flush rolls back the pending write of the squashed slot
        ex_ready = 1'b0; if_valid = 1'b1; instruction = 16'h1423;   // ADD R2,R0,#3
        tick();
        check_eq("fl_valid", 32'(ex_valid), 1);
        check_eq("fl_cnt2",  32'(u_dut.u_sb.r_count[2]), 1);
        instruction = 16'h10A0;                                     // ADD R0,R2,#0
        #1 check_eq("fl_raw", 32'(hazard_stall), 1);
        flush = 1'b1;
        #1 check_eq("fl_block", 32'(id_ready), 0);
        tick();
        flush = 1'b0;
        check_eq("fl_squash", 32'(ex_valid), 0);
        check_eq("fl_rollback", 32'(u_dut.u_sb.r_count[2]), 0);
        #1 check_eq("fl_nostall", 32'(hazard_stall), 0);
        check_eq("fl_ready", 32'(id_ready), 1);
        tick();
        check_eq("fl_issue", 32'(ex_valid), 1);
        check_eq("fl_dest",  32'(ex_dest_reg), 0);
        if_valid = 1'b0; ex_ready = 1'b1;
        wb(3'd0, 16'h0000);
        tick();
        wb_valid = 1'b0;

        // Counter saturation on R5
        if_valid = 1'b1; instruction = 16'h1A21;                    // ADD R5,R0,#1
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("sat_issue", 32'(id_ready), 1);
            tick();
        end
        check_eq("sat_cnt3", 32'(u_dut.u_sb.r_count[5]), 3);
        #1 check_eq("sat_stall", 32'(hazard_stall), 1);
        check_eq("sat_ready", 32'(id_ready), 0);
        tick();
        check_eq("sat_drain", 32'(ex_valid), 0);
        wb(3'd5, 16'h0055);
        #1 check_eq("sat_wb_stall", 32'(hazard_stall), 1);
        tick();
        check_eq("sat_cnt2", 32'(u_dut.u_sb.r_count[5]), 2);
        #1 check_eq("sat_both_ready", 32'(id_ready), 1);
        tick();
        check_eq("sat_both_cnt", 32'(u_dut.u_sb.r_count[5]), 2);
        check_eq("sat_both_valid", 32'(ex_valid), 1);
        if_valid = 1'b0;
        tick();
        tick();
        wb_valid = 1'b0;
        check_eq("sat_cnt0", 32'(u_dut.u_sb.r_count[5]), 0);
        check_eq("sat_err",  32'(sb_err), 0);

        // Stray writeback to R6
        wb(3'd6, 16'h0066);
        tick();
        wb_valid = 1'b0;
        check_eq("err_set",  32'(sb_err), 1);
        check_eq("err_cnt6", 32'(u_dut.u_sb.r_count[6]), 0);
        tick();
        check_eq("err_sticky", 32'(sb_err), 1);

        // STB reads its data register as a source, staged in the upper byte
        if_valid = 1'b1; instruction = 16'h3C00;                    // STB R6,R0,#0
        #1 check_eq("stb_ready", 32'(id_ready), 1);
        tick();
        check_eq("stb_dval", 32'(ex_dest_val), 32'h6600);
        check_eq("stb_wr",   32'(ex_ctrl.mem_write), 1);

        // Asynchronous reset while the slot is live
        instruction = 16'h13A0;                                     // ADD R1,R6,#0
        tick();
        check_eq("pre_rst_sr1",  32'(ex_sr1), 32'h0066);
        check_eq("pre_rst_cnt1", 32'(u_dut.u_sb.r_count[1]), 1);
        if_valid = 1'b0; ex_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_eq("arst_valid", 32'(ex_valid), 0);
        check_eq("arst_err",   32'(sb_err), 0);
        check_eq("arst_cnt1",  32'(u_dut.u_sb.r_count[1]), 0);
        check_eq("arst_sr1",   32'(ex_sr1), 0);
        check_eq("arst_ctrl",  32'(ex_ctrl), 0);
        #1 reset = 1'b0;
        tick();
        check_eq("post_rst_valid", 32'(ex_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
